// File: rtl/bp_fe_icache_fill_responder.sv
// bp_fe_icache_fill_responder: LCE-side fill engine for FE I$ misses.
// One request at a time: fetch block (or dword), write data, then tag, then pulse complete.
// Ports:
//   cache_req_*            : request {type, addr}, victim-way metadata, complete pulse
//   mem_cmd_* / mem_resp_* : memory command {uncached, addr} and fill response
//   data_mem_pkt_*         : {opcode, index, way, data} I$ data write
//   tag_mem_pkt_*          : {index, way, ptag} I$ tag write (set valid)
//   miss_count_o, last_fill_latency_o : only with BP_FE_FILL_PERF_EN
module bp_fe_icache_fill_responder #(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int ptag_width_p  = 28
) (
`ifdef BP_FE_FILL_PERF_EN
  output logic [31:0] miss_count_o,
  output logic [15:0] last_fill_latency_o,
`endif
  input  logic clk_i,
  input  logic reset_n_i,

  input  logic [paddr_width_p+1:0] cache_req_i,
  input  logic cache_req_v_i,
  output logic cache_req_ready_o,
  input  logic [$clog2(assoc_p)-1:0] cache_req_metadata_i,
  input  logic cache_req_metadata_v_i,
  output logic cache_req_complete_o,

  output logic [paddr_width_p:0] mem_cmd_o,
  output logic mem_cmd_v_o,
  input  logic mem_cmd_ready_i,

  input  logic [block_width_p-1:0] mem_resp_i,
  input  logic mem_resp_v_i,
  output logic mem_resp_yumi_o,

  output logic [$clog2(sets_p)+$clog2(assoc_p)+block_width_p:0] data_mem_pkt_o,
  output logic data_mem_pkt_v_o,
  input  logic data_mem_pkt_yumi_i,

  output logic [$clog2(sets_p)+$clog2(assoc_p)+ptag_width_p-1:0] tag_mem_pkt_o,
  output logic tag_mem_pkt_v_o,
  input  logic tag_mem_pkt_yumi_i
);

  localparam int index_w  = $clog2(sets_p);
  localparam int way_w    = $clog2(assoc_p);
  localparam int offset_w = $clog2(block_width_p/8);

  localparam logic [1:0] req_miss_lp     = 2'd0;
  localparam logic [1:0] req_uncached_lp = 2'd1;

  localparam logic [paddr_width_p-1:0] blk_mask_lp =
    {paddr_width_p{1'b1}} << offset_w;
  localparam logic [paddr_width_p-1:0] dw_mask_lp =
    {paddr_width_p{1'b1}} << 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_META,
    S_SEND_CMD,
    S_WAIT_RESP,
    S_WR_DATA,
    S_WR_TAG,
    S_DONE
  } state_e;

  state_e state_q;

  logic ready_q;
  logic cmd_v_q;
  logic data_v_q;
  logic tag_v_q;
  logic complete_q;
  logic uncached_q;
  logic [paddr_width_p-1:0] addr_q;
  logic [way_w-1:0] way_q;
  logic [block_width_p-1:0] data_q;

  logic [1:0] req_type;
  logic [paddr_width_p-1:0] req_addr;
  logic req_accept;
  logic [index_w-1:0] idx;
  logic [paddr_width_p-1:0] cmd_addr;

  assign req_type   = cache_req_i[paddr_width_p+1 -: 2];
  assign req_addr   = cache_req_i[paddr_width_p-1:0];
  assign req_accept = (state_q == S_IDLE) & ready_q & cache_req_v_i;

  assign idx      = addr_q[offset_w +: index_w];
  assign cmd_addr = addr_q & (uncached_q ? dw_mask_lp : blk_mask_lp);

  // Stale responses are drained in IDLE; ready_q keeps this quiet in reset.
  assign mem_resp_yumi_o = mem_resp_v_i
    & ((state_q == S_WAIT_RESP) | ((state_q == S_IDLE) & ready_q));

  assign cache_req_ready_o    = ready_q;
  assign cache_req_complete_o = complete_q;
  assign mem_cmd_v_o          = cmd_v_q;
  assign mem_cmd_o            = {uncached_q, cmd_addr};
  assign data_mem_pkt_v_o     = data_v_q;
  assign data_mem_pkt_o       = {uncached_q, idx, way_q, data_q};
  assign tag_mem_pkt_v_o      = tag_v_q;
  assign tag_mem_pkt_o        =
    {idx, way_q, addr_q[paddr_width_p-1 -: ptag_width_p]};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      cmd_v_q    <= 1'b0;
      data_v_q   <= 1'b0;
      tag_v_q    <= 1'b0;
      complete_q <= 1'b0;
      uncached_q <= 1'b0;
      addr_q     <= '0;
      way_q      <= '0;
      data_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_accept) begin
            ready_q    <= 1'b0;
            addr_q     <= req_addr;
            uncached_q <= (req_type == req_uncached_lp);
            if (req_type == req_miss_lp) begin
              if (cache_req_metadata_v_i) begin
                way_q   <= cache_req_metadata_i;
                cmd_v_q <= 1'b1;
                state_q <= S_SEND_CMD;
              end else begin
                state_q <= S_WAIT_META;
              end
            end else if (req_type == req_uncached_lp) begin
              way_q   <= '0;
              cmd_v_q <= 1'b1;
              state_q <= S_SEND_CMD;
            end else begin
              // Illegal type: no memory traffic, just retire it.
              complete_q <= 1'b1;
              state_q    <= S_DONE;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WAIT_META: begin
          if (cache_req_metadata_v_i) begin
            way_q   <= cache_req_metadata_i;
            cmd_v_q <= 1'b1;
            state_q <= S_SEND_CMD;
          end
        end
        S_SEND_CMD: begin
          if (mem_cmd_ready_i) begin
            cmd_v_q <= 1'b0;
            state_q <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (mem_resp_v_i) begin
            data_q <= uncached_q
              ? {{(block_width_p-64){1'b0}}, mem_resp_i[63:0]}
              : mem_resp_i;
            data_v_q <= 1'b1;
            state_q  <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (data_mem_pkt_yumi_i) begin
            data_v_q <= 1'b0;
            if (uncached_q) begin
              complete_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              tag_v_q <= 1'b1;
              state_q <= S_WR_TAG;
            end
          end
        end
        S_WR_TAG: begin
          if (tag_mem_pkt_yumi_i) begin
            tag_v_q    <= 1'b0;
            complete_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          complete_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BP_FE_FILL_PERF_EN
  logic [31:0] miss_cnt_q;
  logic [15:0] lat_cnt_q;
  logic [15:0] last_lat_q;

  assign miss_count_o        = miss_cnt_q;
  assign last_fill_latency_o = last_lat_q;

  // lat_cnt_q holds the cycle number since accept, so it reads
  // accept->complete distance while in DONE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      miss_cnt_q <= '0;
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      if (req_accept) begin
        lat_cnt_q <= 16'd1;
        if (req_type == req_miss_lp)
          miss_cnt_q <= miss_cnt_q + 32'd1;
      end else if (state_q != S_IDLE && lat_cnt_q != 16'hFFFF) begin
        lat_cnt_q <= lat_cnt_q + 16'd1;
      end
      if (state_q == S_DONE)
        last_lat_q <= lat_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_icache_fill_responder.sv
// tb_bp_fe_icache_fill_responder: directed bench for the I$ fill responder.
// Drives and samples on the falling edge; expected values are hand-derived.
module tb_bp_fe_icache_fill_responder;

  logic clk = 1'b0;
  logic reset_n_i;
  logic [41:0] cache_req_i;
  logic cache_req_v_i;
  logic cache_req_ready_o;
  logic [2:0] cache_req_metadata_i;
  logic cache_req_metadata_v_i;
  logic cache_req_complete_o;
  logic [40:0] mem_cmd_o;
  logic mem_cmd_v_o;
  logic mem_cmd_ready_i;
  logic [511:0] mem_resp_i;
  logic mem_resp_v_i;
  logic mem_resp_yumi_o;
  logic [521:0] data_mem_pkt_o;
  logic data_mem_pkt_v_o;
  logic data_mem_pkt_yumi_i;
  logic [36:0] tag_mem_pkt_o;
  logic tag_mem_pkt_v_o;
  logic tag_mem_pkt_yumi_i;
`ifdef BP_FE_FILL_PERF_EN
  logic [31:0] miss_count_o;
  logic [15:0] last_fill_latency_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_fe_icache_fill_responder dut (
`ifdef BP_FE_FILL_PERF_EN
    .miss_count_o(miss_count_o),
    .last_fill_latency_o(last_fill_latency_o),
`endif
    .clk_i(clk),
    .reset_n_i(reset_n_i),
    .cache_req_i(cache_req_i),
    .cache_req_v_i(cache_req_v_i),
    .cache_req_ready_o(cache_req_ready_o),
    .cache_req_metadata_i(cache_req_metadata_i),
    .cache_req_metadata_v_i(cache_req_metadata_v_i),
    .cache_req_complete_o(cache_req_complete_o),
    .mem_cmd_o(mem_cmd_o),
    .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i),
    .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .data_mem_pkt_o(data_mem_pkt_o),
    .data_mem_pkt_v_o(data_mem_pkt_v_o),
    .data_mem_pkt_yumi_i(data_mem_pkt_yumi_i),
    .tag_mem_pkt_o(tag_mem_pkt_o),
    .tag_mem_pkt_v_o(tag_mem_pkt_v_o),
    .tag_mem_pkt_yumi_i(tag_mem_pkt_yumi_i)
  );

  task automatic chk(input string tag,
                     input logic [599:0] got,
                     input logic [599:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Minimum-latency miss: accept c0, cmd c1, resp c2, data c3, tag c4, complete c5.
  task automatic run_miss(input logic [39:0] a, input logic [2:0] w,
                          input logic [511:0] r, input logic [5:0] idx,
                          input logic [27:0] pt, input logic [39:0] ca);
    chk("m_ready", cache_req_ready_o, 1);
    cache_req_i = {2'b00, a};
    cache_req_v_i = 1'b1;
    cache_req_metadata_i = w;
    cache_req_metadata_v_i = 1'b1;
    step();
    cache_req_v_i = 1'b0;
    cache_req_metadata_v_i = 1'b0;
    chk("m_cmd_v", mem_cmd_v_o, 1);
    chk("m_cmd", mem_cmd_o, {1'b0, ca});
    chk("m_busy", cache_req_ready_o, 0);
    step();
    chk("m_cmd_off", mem_cmd_v_o, 0);
    mem_resp_i = r;
    mem_resp_v_i = 1'b1;
    #1;
    chk("m_yumi", mem_resp_yumi_o, 1);
    step();
    mem_resp_v_i = 1'b0;
    chk("m_data_v", data_mem_pkt_v_o, 1);
    chk("m_data", data_mem_pkt_o, {1'b0, idx, w, r});
    chk("m_tag_early", tag_mem_pkt_v_o, 0);
    step();
    chk("m_data_off", data_mem_pkt_v_o, 0);
    chk("m_tag_v", tag_mem_pkt_v_o, 1);
    chk("m_tag", tag_mem_pkt_o, {idx, w, pt});
    chk("m_cpl_early", cache_req_complete_o, 0);
    step();
    chk("m_tag_off", tag_mem_pkt_v_o, 0);
    chk("m_cpl", cache_req_complete_o, 1);
    chk("m_rdy_cpl", cache_req_ready_o, 0);
    step();
    chk("m_cpl_off", cache_req_complete_o, 0);
    chk("m_rdy_back", cache_req_ready_o, 1);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    step();
  endtask

  initial begin
    logic [511:0] p1;
    logic [511:0] p2;
    logic [511:0] p3;
    p1 = {16{32'hC0DE_0001}};
    p2 = {8{64'h0123_4567_89AB_CDEF}};
    p3 = {8{64'h1122_3344_5566_7788}};

    reset_n_i = 1'b0;
    cache_req_i = '0;
    cache_req_v_i = 1'b0;
    cache_req_metadata_i = '0;
    cache_req_metadata_v_i = 1'b0;
    mem_cmd_ready_i = 1'b1;
    mem_resp_i = '0;
    mem_resp_v_i = 1'b1;
    data_mem_pkt_yumi_i = 1'b1;
    tag_mem_pkt_yumi_i = 1'b1;

    // reset state, with a response already pending
    step();
    chk("rst_ready", cache_req_ready_o, 0);
    chk("rst_cmd_v", mem_cmd_v_o, 0);
    chk("rst_data_v", data_mem_pkt_v_o, 0);
    chk("rst_tag_v", tag_mem_pkt_v_o, 0);
    chk("rst_cpl", cache_req_complete_o, 0);
    chk("rst_yumi", mem_resp_yumi_o, 0);
    mem_resp_v_i = 1'b0;
    reset_n_i = 1'b1;
    #1;
    chk("rel_ready", cache_req_ready_o, 0);
    step();
    chk("rel_ready_up", cache_req_ready_o, 1);

    // 1: miss, metadata with request, everything ready
    run_miss(40'h00_8000_1234, 3'd3, p1, 6'h08, 28'h008_0001,
             40'h00_8000_1200);

    // 2: late metadata and late data yumi
    data_mem_pkt_yumi_i = 1'b0;
    cache_req_i = {2'b00, 40'h00_0000_4040};
    cache_req_v_i = 1'b1;
    step();
    cache_req_v_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_no_cmd", mem_cmd_v_o, 0);
      if (i == 4) begin
        cache_req_metadata_i = 3'd5;
        cache_req_metadata_v_i = 1'b1;
      end
      if (i < 4) step();
    end
    step();
    cache_req_metadata_v_i = 1'b0;
    chk("t2_cmd_v", mem_cmd_v_o, 1);
    chk("t2_cmd", mem_cmd_o, {1'b0, 40'h00_0000_4040});
    step();
    mem_resp_i = p2;
    mem_resp_v_i = 1'b1;
    step();
    mem_resp_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_data_v", data_mem_pkt_v_o, 1);
      chk("t2_data", data_mem_pkt_o, {1'b0, 6'h01, 3'd5, p2});
      chk("t2_no_tag", tag_mem_pkt_v_o, 0);
      if (i == 3) data_mem_pkt_yumi_i = 1'b1;
      step();
    end
    chk("t2_data_off", data_mem_pkt_v_o, 0);
    chk("t2_tag_v", tag_mem_pkt_v_o, 1);
    chk("t2_tag", tag_mem_pkt_o, {6'h01, 3'd5, 28'h000_0004});
    step();
    chk("t2_cpl", cache_req_complete_o, 1);
    step();
    chk("t2_rdy", cache_req_ready_o, 1);

    // 3: uncached, command held while memory is not ready
    mem_cmd_ready_i = 1'b0;
    cache_req_i = {2'b01, 40'h00_0000_100C};
    cache_req_v_i = 1'b1;
    cache_req_metadata_i = 3'd6;
    step();
    cache_req_v_i = 1'b0;
    chk("t3_cmd_v", mem_cmd_v_o, 1);
    chk("t3_cmd", mem_cmd_o, {1'b1, 40'h00_0000_1008});
    step();
    chk("t3_cmd_hold_v", mem_cmd_v_o, 1);
    chk("t3_cmd_hold", mem_cmd_o, {1'b1, 40'h00_0000_1008});
    mem_cmd_ready_i = 1'b1;
    step();
    chk("t3_cmd_off", mem_cmd_v_o, 0);
    mem_resp_i = p3;
    mem_resp_v_i = 1'b1;
    step();
    mem_resp_v_i = 1'b0;
    chk("t3_data_v", data_mem_pkt_v_o, 1);
    chk("t3_data", data_mem_pkt_o,
        {1'b1, 6'h00, 3'd0, 448'h0, 64'h1122_3344_5566_7788});
    step();
    chk("t3_no_tag", tag_mem_pkt_v_o, 0);
    chk("t3_cpl", cache_req_complete_o, 1);
    step();
    chk("t3_no_tag2", tag_mem_pkt_v_o, 0);
    chk("t3_rdy", cache_req_ready_o, 1);

    // 5: request valid held; next one (illegal type) waits for complete
    cache_req_i = {2'b00, 40'h00_0000_2000};
    cache_req_v_i = 1'b1;
    cache_req_metadata_i = 3'd2;
    cache_req_metadata_v_i = 1'b1;
    step();
    cache_req_i = {2'b10, 40'h00_0000_3000};
    cache_req_metadata_v_i = 1'b0;
    chk("t5_cmd", mem_cmd_o, {1'b0, 40'h00_0000_2000});
    step();
    mem_resp_i = p1;
    mem_resp_v_i = 1'b1;
    step();
    mem_resp_v_i = 1'b0;
    chk("t5_busy3", cache_req_ready_o, 0);
    step();
    chk("t5_busy4", cache_req_ready_o, 0);
    step();
    chk("t5_cpl1", cache_req_complete_o, 1);
    chk("t5_busy5", cache_req_ready_o, 0);
    step();
    chk("t5_cpl1_off", cache_req_complete_o, 0);
    chk("t5_rdy6", cache_req_ready_o, 1);
    step();
    cache_req_v_i = 1'b0;
    chk("t5_ill_cpl", cache_req_complete_o, 1);
    chk("t5_ill_nocmd", mem_cmd_v_o, 0);
    step();
    chk("t5_ill_cpl_off", cache_req_complete_o, 0);
    chk("t5_rdy8", cache_req_ready_o, 1);

    // 4: reset in WAIT_RESP, stale response afterwards
    cache_req_i = {2'b00, 40'h00_0000_0040};
    cache_req_v_i = 1'b1;
    cache_req_metadata_i = 3'd1;
    cache_req_metadata_v_i = 1'b1;
    step();
    cache_req_v_i = 1'b0;
    cache_req_metadata_v_i = 1'b0;
    chk("t4_cmd_v", mem_cmd_v_o, 1);
    step();
    reset_n_i = 1'b0;
    mem_resp_i = p2;
    mem_resp_v_i = 1'b1;
    #1;
    chk("t4_rst_yumi", mem_resp_yumi_o, 0);
    chk("t4_rst_ready", cache_req_ready_o, 0);
    step();
    step();
    reset_n_i = 1'b1;
    #1;
    chk("t4_rel_ready", cache_req_ready_o, 0);
    step();
    chk("t4_stale_yumi", mem_resp_yumi_o, 1);
    chk("t4_ready", cache_req_ready_o, 1);
    mem_resp_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_data", data_mem_pkt_v_o, 0);
      chk("t4_no_tag", tag_mem_pkt_v_o, 0);
      chk("t4_no_cpl", cache_req_complete_o, 0);
      step();
    end
    run_miss(40'hFF_FFFF_FFC0, 3'd7, p3, 6'h3F, 28'hFFF_FFFF,
             40'hFF_FFFF_FFC0);

`ifdef BP_FE_FILL_PERF_EN
    // 6: counters
    do_reset();
    chk("p_rst_cnt", miss_count_o, 0);
    chk("p_rst_lat", last_fill_latency_o, 0);
    for (int i = 0; i < 3; i++)
      run_miss(40'h00_0000_0080, 3'd4, p1, 6'h02, 28'h000_0000,
               40'h00_0000_0080);
    chk("p_cnt3", miss_count_o, 3);
    chk("p_lat5", last_fill_latency_o, 5);
    dut.miss_cnt_q = 32'hFFFF_FFFF;
    run_miss(40'h00_0000_0080, 3'd4, p1, 6'h02, 28'h000_0000,
             40'h00_0000_0080);
    chk("p_wrap", miss_count_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
